// File: rtl/axis_ctrl_pkt_arbiter.sv
// N:1 packet-level round-robin arbiter for AXIS-Ctrl with MTU truncation.
// Define AXIS_CTRL_ARB_STATS_EN to add per-port packet counters and a truncation counter.
module axis_ctrl_pkt_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DWIDTH     = 64,
  parameter int MTU_LOG2   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]        s_axis_tlast,
  input  logic [NUM_INPUTS-1:0]        s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]            m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [NUM_INPUTS-1:0]        grant,
  output logic                         mtu_err
`ifdef AXIS_CTRL_ARB_STATS_EN
  ,
  output logic [NUM_INPUTS*16-1:0]     pkt_count,
  output logic [15:0]                  trunc_count
`endif
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [NUM_INPUTS-1:0] grant_nxt;
  logic [IW-1:0]         gidx, gidx_nxt;
  logic [IW-1:0]         last_grant, last_grant_nxt;
  logic [MTU_LOG2-1:0]   cnt, cnt_nxt;
  logic                  mtu_err_nxt;
  logic                  at_limit;
  logic                  out_hs;
  logic                  found;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         sel;
  logic [DWIDTH-1:0]     in_data [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign in_data[i] = s_axis_tdata[i*DWIDTH +: DWIDTH];
  end

  // Rotating priority search: first requester at or after last_grant+1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_INPUTS);
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // The counter holds the index of the current line, so all-ones is the last legal line.
  assign at_limit     = &cnt;
  assign m_axis_tdata = in_data[gidx];

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    mtu_err_nxt    = 1'b0;
    s_axis_tready  = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    out_hs         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = PASS;
          grant_nxt      = NUM_INPUTS'(1) << sel;
          gidx_nxt       = sel;
          last_grant_nxt = sel;
          cnt_nxt        = '0;
        end
      end
      PASS: begin
        m_axis_tvalid       = s_axis_tvalid[gidx];
        m_axis_tlast        = s_axis_tlast[gidx] | at_limit;
        s_axis_tready[gidx] = m_axis_tready;
        out_hs              = m_axis_tvalid & m_axis_tready;
        if (out_hs) begin
          if (s_axis_tlast[gidx]) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end else if (at_limit) begin
            state_nxt   = DRAIN;
            mtu_err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + MTU_LOG2'(1);
          end
        end
      end
      DRAIN: begin
        // The rest of an oversize packet is swallowed so the source can finish it.
        s_axis_tready[gidx] = 1'b1;
        if (s_axis_tvalid[gidx] && s_axis_tlast[gidx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_INPUTS - 1);
      cnt        <= '0;
      mtu_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      mtu_err    <= mtu_err_nxt;
    end
  end

`ifdef AXIS_CTRL_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_INPUTS];
  logic [15:0] trunc_q;

  // NOTE: these per-port counters are plain flops with a reset, not a RAM, because software expects zero after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) pkt_cnt_q[i] <= '0;
      trunc_q <= '0;
    end else begin
      if (out_hs && m_axis_tlast && (pkt_cnt_q[gidx] != 16'hFFFF))
        pkt_cnt_q[gidx] <= pkt_cnt_q[gidx] + 16'd1;
      if (mtu_err && (trunc_q != 16'hFFFF))
        trunc_q <= trunc_q + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_stats
    assign pkt_count[i*16 +: 16] = pkt_cnt_q[i];
  end
  assign trunc_count = trunc_q;
`endif

endmodule

// File: tb/tb_axis_ctrl_pkt_arbiter.sv
// Self-checking bench for axis_ctrl_pkt_arbiter: vector table, directed corner cases,
// and random traffic scored against a packet-level reference model.
module tb_axis_ctrl_pkt_arbiter;
  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int ML  = 5;
  localparam int MTU = 1 << ML;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [N-1:0]    grant;
  logic            mtu_err;
`ifdef AXIS_CTRL_ARB_STATS_EN
  logic [N*16-1:0] pkt_count;
  logic [15:0]     trunc_count;
`endif

  axis_ctrl_pkt_arbiter #(.NUM_INPUTS(N), .DWIDTH(DW), .MTU_LOG2(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant(grant), .mtu_err(mtu_err)
`ifdef AXIS_CTRL_ARB_STATS_EN
    , .pkt_count(pkt_count), .trunc_count(trunc_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] vld;
    logic [N-1:0] lst;
    logic [63:0]  data;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_sready;
    logic         e_mvalid;
    logic         e_mlast;
    logic [63:0]  e_mdata;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] vld, logic [N-1:0] lst, logic [63:0] data,
                              logic [N-1:0] eg, logic [N-1:0] es, logic emv, logic eml,
                              logic [63:0] ed);
    vec_t v;
    v.vld = vld; v.lst = lst; v.data = data; v.e_grant = eg; v.e_sready = es;
    v.e_mvalid = emv; v.e_mlast = eml; v.e_mdata = ed;
    return v;
  endfunction

  // Sources: per-port queues of packets (length + id); beat k of a packet has a unique word.
  int   q_len [N][$];
  int   q_id  [N][$];
  bit   src_on  [N];
  int   src_pos [N];
  int   next_id = 1;
  int   vld_pct = 100;
  int   rdy_pct = 100;
  bit   rdy_q[$];
  logic [N-1:0] samp_sready;

  // Reference model, tracked in packets: who owns the output and how many input lines it has consumed.
  bit m_busy;
  int m_owner, m_sent, m_last;
  bit exp_mtu, hs_in;
  int pkt_done [N];

  // Observations of the DUT.
  int   dut_beats, dut_mtu;
  int   dut_glog[$];
  bit   prev_g_zero, prev_stall;
  logic [63:0] prev_data;
  logic prev_last;

  function automatic logic [63:0] word(int p, int id, int k);
    logic [31:0] pp, ii, kk;
    pp = p; ii = id; kk = k;
    return {pp[7:0], ii[23:0], kk};
  endfunction

  task automatic load(input int p, input int len);
    q_len[p].push_back(len);
    q_id[p].push_back(next_id);
    next_id++;
  endtask

  function automatic bit pending();
    for (int p = 0; p < N; p++) if (q_len[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      if (!src_on[p] && q_len[p].size() != 0 && $urandom_range(99) < vld_pct) src_on[p] = 1'b1;
      s_axis_tvalid[p] = src_on[p];
      s_axis_tdata[p*DW +: DW] = src_on[p] ? word(p, q_id[p][0], src_pos[p]) : 64'd0;
      s_axis_tlast[p] = src_on[p] && (src_pos[p] == q_len[p][0] - 1);
    end
    if (rdy_q.size() != 0) m_axis_tready = rdy_q.pop_front();
    else m_axis_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, es;
    logic emv, eml;
    int len, lim;
    eg = '0; es = '0; emv = 1'b0; eml = 1'b0; hs_in = 1'b0;
    if (m_busy) begin
      len = q_len[m_owner][0];
      lim = (len < MTU) ? len : MTU;
      eg[m_owner] = 1'b1;
      if (m_sent < lim) begin
        emv = src_on[m_owner];
        es[m_owner] = m_axis_tready;
        eml = (m_sent == lim - 1);
      end else begin
        es[m_owner] = 1'b1;
      end
      hs_in = src_on[m_owner] && es[m_owner];
    end
    check("grant", grant, eg);
    check("m_tvalid", m_axis_tvalid, emv);
    check("s_tready", s_axis_tready, es);
    check("mtu_err", mtu_err, exp_mtu);
    if (emv) begin
      check("m_tdata", m_axis_tdata, word(m_owner, q_id[m_owner][0], m_sent));
      check("m_tlast", m_axis_tlast, eml);
    end
    if (prev_stall) begin
      check("stall_data", m_axis_tdata, prev_data);
      check("stall_last", m_axis_tlast, prev_last);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) dut_beats++;
    if (mtu_err) dut_mtu++;
    if (grant != '0 && prev_g_zero)
      for (int p = 0; p < N; p++) if (grant[p]) dut_glog.push_back(p);
    prev_g_zero = (grant == '0);
    samp_sready = s_axis_tready;
  endtask

  task automatic update();
    int len, lim;
    bit picked;
    exp_mtu = 1'b0;
    if (!m_busy) begin
      picked = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!picked && src_on[(m_last + k) % N]) begin
          picked  = 1'b1;
          m_owner = (m_last + k) % N;
        end
      end
      if (picked) begin
        m_busy = 1'b1; m_sent = 0; m_last = m_owner;
      end
    end else if (hs_in) begin
      len = q_len[m_owner][0];
      lim = (len < MTU) ? len : MTU;
      if (m_sent == lim - 1) pkt_done[m_owner]++;
      m_sent++;
      if (m_sent == MTU && len > MTU) exp_mtu = 1'b1;
      if (m_sent == len) m_busy = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      if (src_on[p] && samp_sready[p]) begin
        src_on[p] = 1'b0;
        src_pos[p]++;
        if (src_pos[p] == q_len[p][0]) begin
          void'(q_len[p].pop_front());
          void'(q_id[p].pop_front());
          src_pos[p] = 0;
        end
      end
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic run_until_idle(input string name, input int bound);
    int n = 0;
    while ((m_busy || pending()) && n < bound) begin
      step();
      n++;
    end
    check(name, (n < bound), 1'b1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) begin
      q_len[p].delete(); q_id[p].delete();
      src_on[p] = 1'b0; src_pos[p] = 0; pkt_done[p] = 0;
    end
    rdy_q.delete();
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    m_busy = 1'b0; m_last = N - 1; exp_mtu = 1'b0; hs_in = 1'b0;
    prev_stall = 1'b0; prev_g_zero = 1'b1; samp_sready = '0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_mtu_err", mtu_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];
  int   exp_beats, exp_trunc, n;

  initial begin
    rst_n = 1'b0;
    apply_reset();

    // Vector table: 3-line packet on port 2, then single-line packets exercising rotation.
    vecs[0] = mk(4'b0100, 4'b0000, 64'hA, 4'b0000, 4'b0000, 0, 0, 64'h0);
    vecs[1] = mk(4'b0100, 4'b0000, 64'hA, 4'b0100, 4'b0100, 1, 0, 64'hA);
    vecs[2] = mk(4'b0100, 4'b0000, 64'hB, 4'b0100, 4'b0100, 1, 0, 64'hB);
    vecs[3] = mk(4'b0100, 4'b0100, 64'hC, 4'b0100, 4'b0100, 1, 1, 64'hC);
    vecs[4] = mk(4'b0000, 4'b0000, 64'h0, 4'b0000, 4'b0000, 0, 0, 64'h0);
    vecs[5] = mk(4'b1001, 4'b1001, 64'hD, 4'b0000, 4'b0000, 0, 0, 64'h0);
    vecs[6] = mk(4'b1001, 4'b1001, 64'hD, 4'b1000, 4'b1000, 1, 1, 64'hD);
    vecs[7] = mk(4'b0001, 4'b0001, 64'hD, 4'b0000, 4'b0000, 0, 0, 64'h0);
    vecs[8] = mk(4'b0001, 4'b0001, 64'hD, 4'b0001, 4'b0001, 1, 1, 64'hD);
    vecs[9] = mk(4'b0000, 4'b0000, 64'h0, 4'b0000, 4'b0000, 0, 0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = vecs[i].vld;
      s_axis_tlast  = vecs[i].lst;
      s_axis_tdata  = {N{vecs[i].data}};
      m_axis_tready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
      check($sformatf("vec%0d_s_tready", i), s_axis_tready, vecs[i].e_sready);
      check($sformatf("vec%0d_m_tvalid", i), m_axis_tvalid, vecs[i].e_mvalid);
      check($sformatf("vec%0d_mtu_err", i), mtu_err, 0);
      if (vecs[i].e_mvalid) begin
        check($sformatf("vec%0d_m_tdata", i), m_axis_tdata, vecs[i].e_mdata);
        check($sformatf("vec%0d_m_tlast", i), m_axis_tlast, vecs[i].e_mlast);
      end
      @(posedge clk);
      #1;
    end

    // Round robin: every port holds three 2-line packets.
    apply_reset();
    dut_glog.delete(); dut_beats = 0;
    for (int j = 0; j < 3; j++) for (int p = 0; p < N; p++) load(p, 2);
    run_until_idle("rr_timeout", 200);
    check("rr_beats", dut_beats, 24);
    check("rr_grants", dut_glog.size(), 12);
    for (int i = 0; i < dut_glog.size(); i++) check($sformatf("rr_order%0d", i), dut_glog[i], i % N);

    // Backpressure on a 4-line packet from port 1.
    dut_beats = 0;
    rdy_q = '{1, 0, 0, 1, 1, 0, 1};
    load(1, 4);
    run_until_idle("bp_timeout", 100);
    check("bp_beats", dut_beats, 4);

    // Truncation of a 40-line packet, then an exact-MTU packet.
    apply_reset();
    dut_glog.delete(); dut_beats = 0; dut_mtu = 0;
    load(0, 40); load(1, 2);
    run_until_idle("mtu_timeout", 200);
    check("mtu_pulses", dut_mtu, 1);
    check("mtu_beats", dut_beats, MTU + 2);
    check("mtu_first", dut_glog[0], 0);
    check("mtu_next", dut_glog[1], 1);
    dut_beats = 0; dut_mtu = 0;
    load(0, MTU);
    run_until_idle("exact_timeout", 200);
    check("exact_pulses", dut_mtu, 0);
    check("exact_beats", dut_beats, MTU);

    // Reset asserted while line 3 of a 10-line packet is on the output.
    apply_reset();
    dut_beats = 0; n = 0;
    load(0, 10);
    while (dut_beats < 2 && n < 50) begin
      step();
      n++;
    end
    check("mid_timeout", (n < 50), 1'b1);
    drive_inputs();
    #2;
    check("mid_pre_valid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_async_grant", grant, 0);
    check("mid_async_m_tvalid", m_axis_tvalid, 0);
    check("mid_async_s_tready", s_axis_tready, 0);
    check("mid_async_mtu_err", mtu_err, 0);
    apply_reset();
    dut_glog.delete();
    load(2, 1); load(0, 1);
    run_until_idle("post_rst_timeout", 50);
    check("post_rst_first", dut_glog[0], 0);

    // Random traffic against the model.
    vld_pct = 70; rdy_pct = 60;
    exp_beats = 0; exp_trunc = 0; dut_beats = 0; dut_mtu = 0;
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < 6; j++) begin
        int r, len;
        r = $urandom_range(9);
        if (r == 0) len = MTU;
        else if (r == 1) len = MTU + 1 + $urandom_range(8);
        else len = 1 + $urandom_range(MTU - 2);
        load(p, len);
        exp_beats += (len < MTU) ? len : MTU;
        if (len > MTU) exp_trunc++;
      end
    end
    run_until_idle("rand_timeout", 5000);
    check("rand_beats", dut_beats, exp_beats);
    check("rand_trunc", dut_mtu, exp_trunc);

`ifdef AXIS_CTRL_ARB_STATS_EN
    apply_reset();
    vld_pct = 100; rdy_pct = 100;
    load(3, 2); load(3, 3); load(3, 40); load(3, 1); load(3, 5);
    run_until_idle("stats_timeout", 300);
    check("stats_port3", pkt_count[3*16 +: 16], 5);
    check("stats_trunc", trunc_count, 1);
    for (int p = 0; p < 3; p++) check($sformatf("stats_port%0d", p), pkt_count[p*16 +: 16], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_ctrl_pkt_arbiter.md
Name: axis_ctrl_pkt_arbiter

Overview:
- N:1 packet-level round-robin arbiter for AXIS-Ctrl traffic. It shares one crossbar ingress port between several control endpoints, for example the control ports of several blocks feeding one router port of the 2D-torus control crossbar.
- Whole packets are granted, never interleaved.
- Packets longer than the router MTU are truncated, so the router buffers can never be overrun.

Parameters:
- NUM_INPUTS, 4, number of requesting slave ports (2..16).
- DWIDTH, 64, data width per port.
- MTU_LOG2, 5, log2 of the max packet length in lines; max = 2^MTU_LOG2 lines.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_INPUTS*DWIDTH  flattened input data, port i at [i*DWIDTH +: DWIDTH].
- s_axis_tlast  in  NUM_INPUTS  per-port end of packet.
- s_axis_tvalid  in  NUM_INPUTS  per-port valid.
- s_axis_tready  out  NUM_INPUTS  per-port ready.
- m_axis_tdata  out  DWIDTH  arbitrated output data.
- m_axis_tlast  out  1  output end of packet (may be forced on truncation).
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- grant  out  NUM_INPUTS  one-hot current grant; all zero when idle.
- mtu_err  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - state=IDLE, grant=0, line counter=0, mtu_err=0.
  - last-grant pointer = NUM_INPUTS-1, so port 0 has first priority.
  - All s_axis_tready=0, m_axis_tvalid=0.
- Reset released mid-packet: the partial output packet is abandoned. No tlast is generated for it.
- States: IDLE, PASS, DRAIN.
- IDLE:
  - s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is set, select the first requesting port at or after last_grant+1, wrapping modulo NUM_INPUTS.
  - Register grant, update last_grant, clear the counter, then go to PASS on the next cycle.
  - Arbitration latency is one cycle from tvalid to the first output beat. There is one idle bubble between consecutive packets.
- PASS:
  - Combinational pass-through of the granted port: m_tdata/m_tvalid/m_tlast come from port g; s_tready[g]=m_tready.
  - All other s_tready=0.
  - The counter increments on each output handshake.
  - Handshake with s_tlast[g]=1 -> IDLE; grant cleared next cycle.
  - Handshake on line 2^MTU_LOG2 with s_tlast[g]=0 (counter == 2^MTU_LOG2-1):
    - m_tlast is forced to 1 on that beat.
    - mtu_err pulses for one cycle after the beat.
    - State goes to DRAIN.
  - A packet of exactly 2^MTU_LOG2 lines whose tlast falls on the limit line is legal: no error, go to IDLE.
- DRAIN:
  - s_tready[g]=1 and m_tvalid=0; input beats are discarded.
  - On an input handshake with s_tlast[g]=1 -> IDLE.
- Fairness:
  - last_grant updates only on a new grant.
  - A port that drops tvalid while in IDLE loses its turn. No request is remembered.
- A 1-line packet (tlast on the first beat) is legal: counter=0, go to IDLE.
- AXIS rules on the output:
  - Once m_tvalid=1, data and tlast are held until the handshake, provided the input obeys AXIS.
  - The arbiter never changes grant mid-packet.
- Counter width is MTU_LOG2 bits. It never wraps, because DRAIN is entered at the limit.

Optional Feature:
- Macro: AXIS_CTRL_ARB_STATS_EN
- With the macro:
  - Adds output pkt_count [NUM_INPUTS*16], a per-port 16-bit count of packets completed through the output.
  - The count increments on the output tlast handshake, including forced tlast.
  - Counters saturate at 0xFFFF and are cleared by rst_n.
  - Adds output trunc_count [16], the number of mtu_err pulses, also saturating.
- Without the macro: no ports and no counter logic are present. Behaviour is otherwise identical.

Test Plan:
- Single port: port 2 sends a 3-line packet (0xA,0xB,0xC) with m_tready=1.
  - grant=4'b0100 one cycle after tvalid.
  - Output is A,B,C with tlast on C.
  - grant=0 on the following cycle.
- Round-robin: all 4 ports continuously send 2-line packets.
  - Output grant order is 0,1,2,3,0,1…
  - Exactly one bubble between packets; no interleaving.
- Backpressure: port 1 sends a 4-line packet while m_tready toggles 1,0,0,1,1,0,1.
  - m_tdata/m_tlast are stable while stalled.
  - Exactly 4 beats are delivered in order.
  - s_tready[1] mirrors m_tready.
- MTU truncation, MTU_LOG2=5: port 0 sends 40 lines.
  - 32 lines are output, with tlast forced on line 32.
  - mtu_err pulses once.
  - 8 lines are drained with m_tvalid=0.
  - Port 1 is granted next.
  - A 32-line packet with real tlast produces no mtu_err.
- Reset mid-packet: assert rst_n=0 on line 3 of a 10-line packet.
  - s_tready, m_tvalid, grant and mtu_err go to 0 immediately, without waiting for a clock edge.
  - After release, port 0 has priority.
- Stats (macro defined): 5 packets on port 3, one of them over MTU.
  - pkt_count[3]=5, trunc_count=1, other ports 0.
